// File: rtl/wb_pkg.sv
// Shared widths, controller state encoding and a width helper for the
// Wishbone line adapter.
package wb_pkg;

  localparam int DEF_LINE_W = 128;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_MEM_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

  function automatic int log2_w(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < value) r = r + 32'sd1;
    return r;
  endfunction

endpackage

// File: rtl/wb_beat_slicer.sv
// Selects the data word and byte strobes of one beat out of a wide line.
module wb_beat_slicer
  import wb_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int MEM_W  = DEF_MEM_W,
  parameter int BEAT_W = log2_w(DEF_LINE_W / DEF_MEM_W)
) (
  input  logic [LINE_W-1:0]   line_dat,
  input  logic [LINE_W/8-1:0] line_sel,
  input  logic [BEAT_W-1:0]   beat,
  output logic [MEM_W-1:0]    word,
  output logic [MEM_W/8-1:0]  strb
);

  localparam int BEATS   = LINE_W / MEM_W;
  localparam int MSTRB_W = MEM_W / 8;

  // Beat 0 maps to the least-significant word of the line.
  always_comb begin
    word = '0;
    strb = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) begin
        word = line_dat[b*MEM_W +: MEM_W];
        strb = line_sel[b*MSTRB_W +: MSTRB_W];
      end else begin
        word = word;
        strb = strb;
      end
    end
  end

endmodule

// File: rtl/wb_line_adapter.sv
// Wishbone classic responder that splits 128-bit line transfers into
// 32-bit beats on a narrow word-memory port and reassembles read lines.
module wb_line_adapter
  import wb_pkg::*;
#(
  parameter  int LINE_W  = DEF_LINE_W,
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int MEM_W   = DEF_MEM_W,
  localparam int BEATS   = LINE_W / MEM_W,
  localparam int SEL_W   = LINE_W / 8,
  localparam int MSTRB_W = MEM_W / 8,
  localparam int MADDR_W = ADDR_W - log2_w(MSTRB_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  adr_i,
  input  logic [LINE_W-1:0]  dat_i,
  output logic [LINE_W-1:0]  dat_o,
  input  logic               we_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               stb_i,
  input  logic               cyc_i,
  output logic               ack_o,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [MADDR_W-1:0] mem_addr,
  output logic               mem_we,
  output logic [MEM_W-1:0]   mem_wdata,
  output logic [MSTRB_W-1:0] mem_wstrb,
  input  logic [MEM_W-1:0]   mem_rdata
);

  localparam int BEAT_W   = log2_w(BEATS);
  localparam int LINE_OFF = log2_w(SEL_W);
  localparam int LINE_AW  = ADDR_W - LINE_OFF;

  wb_state_e            state_r, state_s;
  logic [BEAT_W-1:0]    beat_r, beat_s;
  logic [LINE_AW-1:0]   adr_r;
  logic                 we_r;
  logic [SEL_W-1:0]     sel_r;
  logic [LINE_W-1:0]    dat_r;

  logic                 done_s, last_s, issue_s, ack_s;
  logic [LINE_AW-1:0]   src_adr_s;
  logic                 src_we_s;
  logic [SEL_W-1:0]     src_sel_s;
  logic [LINE_W-1:0]    src_dat_s;
  logic [MEM_W-1:0]     slice_dat_s;
  logic [MSTRB_W-1:0]   slice_sel_s;
  logic                 mem_valid_s, mem_we_s;
  logic [MADDR_W-1:0]   mem_addr_s;
  logic [MEM_W-1:0]     mem_wdata_s;
  logic [MSTRB_W-1:0]   mem_wstrb_s;
  logic                 unused_adr_s;

  assign unused_adr_s = ^adr_i[LINE_OFF-1:0];
  // A skipped beat (mem_valid low) completes in its single cycle.
  assign done_s = !mem_valid || mem_ready;
  assign last_s = (beat_r == BEAT_W'(BEATS - 1));

  wb_beat_slicer #(
    .LINE_W (LINE_W),
    .MEM_W  (MEM_W),
    .BEAT_W (BEAT_W)
  ) u_slicer (
    .line_dat (src_dat_s),
    .line_sel (src_sel_s),
    .beat     (beat_s),
    .word     (slice_dat_s),
    .strb     (slice_sel_s)
  );

  // State and beat counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      beat_r  <= '0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
    end
  end

  // Next-state logic; cyc_i is judged only once the current beat is done.
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    case (state_r)
      IDLE: begin
        if (cyc_i && stb_i) begin
          state_s = BEAT;
          beat_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      BEAT: begin
        if (!done_s) begin
          state_s = BEAT;
        end else if (!cyc_i) begin
          state_s = IDLE;
        end else if (last_s) begin
          state_s = ACK;
        end else begin
          beat_s = beat_r + BEAT_W'(1);
        end
      end
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered bus outputs; a stalled beat holds as-is.
  always_comb begin
    if (state_r == IDLE) begin
      src_adr_s = adr_i[ADDR_W-1:LINE_OFF];
      src_we_s  = we_i;
      src_sel_s = sel_i;
      src_dat_s = dat_i;
    end else begin
      src_adr_s = adr_r;
      src_we_s  = we_r;
      src_sel_s = sel_r;
      src_dat_s = dat_r;
    end
    issue_s     = (state_s == BEAT) && ((state_r == IDLE) || done_s);
    ack_s       = (state_s == ACK);
    mem_valid_s = mem_valid;
    mem_we_s    = mem_we;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    mem_wstrb_s = mem_wstrb;
    if (issue_s) begin
      mem_valid_s = !src_we_s || (slice_sel_s != '0);
      mem_we_s    = src_we_s;
      mem_addr_s  = {src_adr_s, beat_s};
      mem_wdata_s = src_we_s ? slice_dat_s : '0;
      mem_wstrb_s = src_we_s ? slice_sel_s : '0;
    end else if (state_s == BEAT) begin
      mem_valid_s = mem_valid;
      mem_we_s    = mem_we;
    end else begin
      mem_valid_s = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = '0;
      mem_wdata_s = '0;
      mem_wstrb_s = '0;
    end
  end

  // Output registers, request capture and read-line assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_o     <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      dat_o     <= '0;
      adr_r     <= '0;
      we_r      <= 1'b0;
      sel_r     <= '0;
      dat_r     <= '0;
    end else begin
      ack_o     <= ack_s;
      mem_valid <= mem_valid_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
      mem_wstrb <= mem_wstrb_s;
      if ((state_r == IDLE) && cyc_i && stb_i) begin
        adr_r <= adr_i[ADDR_W-1:LINE_OFF];
        we_r  <= we_i;
        sel_r <= sel_i;
        dat_r <= dat_i;
      end
      if ((state_r == BEAT) && mem_valid && mem_ready && !mem_we) begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat_r == BEAT_W'(b)) dat_o[b*MEM_W +: MEM_W] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_line_adapter.sv
// Self-checking bench for wb_line_adapter: directed scenarios plus randomized
// line transfers against a line-level memory/timing reference model.
module tb_wb_line_adapter;

  localparam int NCYC  = 32;
  localparam int NWORD = 16384;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  adr_i = '0;
  logic [127:0] dat_i = '0;
  logic [127:0] dat_o;
  logic         we_i = 1'b0;
  logic [15:0]  sel_i = '0;
  logic         stb_i = 1'b0;
  logic         cyc_i = 1'b0;
  logic         ack_o;
  logic         mem_valid;
  logic         mem_ready = 1'b1;
  logic [13:0]  mem_addr;
  logic         mem_we;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_rdata;

  logic [31:0] tb_mem  [0:NWORD-1];
  logic [31:0] ref_mem [0:NWORD-1];
  assign mem_rdata = tb_mem[mem_addr];

  int n_vec = 0;
  int n_err = 0;
  bit rdy_pat [0:63];
  bit vlog    [0:63];
  int drop_at;
  bit keep_stb;
  logic [15:0] adr2;
  int ack_cyc, ack_cnt, hold_viol;
  int o_addr[$];  int o_cyc[$];  logic [31:0] o_wdata[$];  logic [3:0] o_wstrb[$];
  int e_addr[$];  int e_cyc[$];  logic [31:0] e_wdata[$];  logic [3:0] e_wstrb[$];
  int exp_ack;
  logic [127:0] model_dat = '0;

  wb_line_adapter dut (
    .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic ready_all();
    for (int n = 0; n < 64; n++) rdy_pat[n] = 1'b1;
    drop_at  = -1;
    keep_stb = 1'b0;
  endtask

  // Reference: which beats move, at which cycle after capture, and what data.
  task automatic model_txn(input logic [15:0] a, input logic w, input logic [15:0] s,
                           input logic [127:0] d);
    int c, base;
    e_addr.delete(); e_cyc.delete(); e_wdata.delete(); e_wstrb.delete();
    base = int'(a[15:4]) * 4;
    c = 1;
    for (int k = 0; k < 4; k++) begin
      logic [3:0]  st;
      logic [31:0] wd;
      st = s[4*k +: 4];
      wd = d[32*k +: 32];
      if (!w || st != 4'h0) begin
        while (!rdy_pat[c]) c++;
        e_addr.push_back(base + k);
        e_cyc.push_back(c);
        e_wdata.push_back(w ? wd : 32'h0);
        e_wstrb.push_back(w ? st : 4'h0);
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (st[b]) ref_mem[base + k][8*b +: 8] = wd[8*b +: 8];
        end else begin
          model_dat[32*k +: 32] = ref_mem[base + k];
        end
      end
      c++;
    end
    exp_ack = c;
  endtask

  // Drives one request and acts as the word memory for NCYC cycles.
  task automatic run_txn(input logic [15:0] a, input logic w, input logic [15:0] s,
                         input logic [127:0] d);
    bit p_stall;
    logic [13:0] p_addr; logic p_we; logic [31:0] p_wdata; logic [3:0] p_wstrb;
    o_addr.delete(); o_cyc.delete(); o_wdata.delete(); o_wstrb.delete();
    ack_cyc = -1; ack_cnt = 0; hold_viol = 0; p_stall = 1'b0;
    p_addr = '0; p_we = 1'b0; p_wdata = '0; p_wstrb = '0;
    for (int n = 0; n < 64; n++) vlog[n] = 1'b0;
    @(negedge clk);
    adr_i = a; we_i = w; sel_i = s; dat_i = d; cyc_i = 1'b1; stb_i = 1'b1;
    mem_ready = rdy_pat[0];
    @(posedge clk);
    for (int n = 1; n <= NCYC; n++) begin
      #1;
      mem_ready = rdy_pat[n];
      if (n == drop_at) begin cyc_i = 1'b0; stb_i = 1'b0; end
      @(negedge clk);
      vlog[n] = mem_valid;
      if (p_stall && (mem_valid !== 1'b1 || mem_addr !== p_addr || mem_we !== p_we ||
                      mem_wdata !== p_wdata || mem_wstrb !== p_wstrb)) hold_viol++;
      p_stall = mem_valid && !mem_ready;
      p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
      if (mem_valid && mem_ready) begin
        o_addr.push_back(int'(mem_addr)); o_cyc.push_back(n);
        o_wdata.push_back(mem_wdata); o_wstrb.push_back(mem_wstrb);
        if (mem_we)
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) tb_mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end
      if (ack_o) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = n;
        if (keep_stb) adr_i = adr2;
        else begin cyc_i = 1'b0; stb_i = 1'b0; end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_vec += 7;
    if (ack_o !== 1'b0)      begin n_err++; $display("FAIL rst_ack got %0b want 0", ack_o); end
    if (mem_valid !== 1'b0)  begin n_err++; $display("FAIL rst_valid got %0b want 0", mem_valid); end
    if (mem_we !== 1'b0)     begin n_err++; $display("FAIL rst_we got %0b want 0", mem_we); end
    if (mem_addr !== 14'h0)  begin n_err++; $display("FAIL rst_addr got %h want 0", mem_addr); end
    if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    if (mem_wstrb !== 4'h0)  begin n_err++; $display("FAIL rst_wstrb got %h want 0", mem_wstrb); end
    if (dat_o !== 128'h0)    begin n_err++; $display("FAIL rst_dat got %h want 0", dat_o); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_read_basic();
    logic [31:0] w4 [4];
    w4 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4; i++) begin tb_mem[72 + i] = w4[i]; ref_mem[72 + i] = w4[i]; end
    ready_all();
    model_txn(16'h0120, 1'b0, 16'hFFFF, 128'h0);
    run_txn(16'h0120, 1'b0, 16'hFFFF, 128'h0);
    n_vec += 4;
    if (ack_cyc !== 5 || exp_ack !== 5) begin n_err++; $display("FAIL rd_ack_cyc got %0d want 5", ack_cyc); end
    if (ack_cnt !== 1) begin n_err++; $display("FAIL rd_ack_cnt got %0d want 1", ack_cnt); end
    if (o_addr.size() !== 4) begin n_err++; $display("FAIL rd_beats got %0d want 4", o_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (o_addr[i] !== 72 + i) begin n_err++; $display("FAIL rd_addr%0d got %h want %h", i, o_addr[i], 72 + i); end
    end
    if (dat_o !== 128'h44444444_33333333_22222222_11111111)
      begin n_err++; $display("FAIL rd_line got %h want 44444444333333332222222211111111", dat_o); end
  endtask

  task automatic test_write_full();
    logic [127:0] d;
    d = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    ready_all();
    model_txn(16'h0040, 1'b1, 16'hFFFF, d);
    run_txn(16'h0040, 1'b1, 16'hFFFF, d);
    n_vec += 4;
    if (ack_cyc !== 5) begin n_err++; $display("FAIL wr_ack_cyc got %0d want 5", ack_cyc); end
    if (ack_cnt !== 1) begin n_err++; $display("FAIL wr_ack_cnt got %0d want 1", ack_cnt); end
    if (dat_o !== model_dat) begin n_err++; $display("FAIL wr_dat_hold got %h want %h", dat_o, model_dat); end
    if (o_addr.size() !== 4) begin n_err++; $display("FAIL wr_beats got %0d want 4", o_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (o_addr[i] !== 16 + i || o_wstrb[i] !== 4'hF || o_wdata[i] !== d[32*i +: 32])
        begin n_err++; $display("FAIL wr_beat%0d got %h/%h/%h want %h/f/%h", i, o_addr[i], o_wstrb[i], o_wdata[i], 16 + i, d[32*i +: 32]); end
    end
  endtask

  task automatic test_write_sparse();
    logic [127:0] d;
    d = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    ready_all();
    model_txn(16'h0080, 1'b1, 16'h0F00, d);
    run_txn(16'h0080, 1'b1, 16'h0F00, d);
    n_vec += 4;
    if (ack_cyc !== 5) begin n_err++; $display("FAIL sp_ack_cyc got %0d want 5", ack_cyc); end
    if (dat_o !== model_dat) begin n_err++; $display("FAIL sp_dat_hold got %h want %h", dat_o, model_dat); end
    if (tb_mem[34] !== ref_mem[34]) begin n_err++; $display("FAIL sp_mem got %h want %h", tb_mem[34], ref_mem[34]); end
    if (o_addr.size() !== 1) begin n_err++; $display("FAIL sp_beats got %0d want 1", o_addr.size()); end
    else begin
      n_vec++;
      if (o_addr[0] !== 34 || o_wstrb[0] !== 4'hF || o_wdata[0] !== 32'hCCCCCCCC || o_cyc[0] !== 3)
        begin n_err++; $display("FAIL sp_beat got %h/%h/%h@%0d want 22/f/cccccccc@3", o_addr[0], o_wstrb[0], o_wdata[0], o_cyc[0]); end
    end
  endtask

  task automatic test_read_stall();
    ready_all();
    rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b0;
    model_txn(16'h0040, 1'b0, 16'hFFFF, 128'h0);
    run_txn(16'h0040, 1'b0, 16'hFFFF, 128'h0);
    n_vec += 4;
    if (ack_cyc !== 8 || exp_ack !== 8) begin n_err++; $display("FAIL st_ack_cyc got %0d want 8", ack_cyc); end
    if (hold_viol !== 0) begin n_err++; $display("FAIL st_hold got %0d want 0", hold_viol); end
    if (dat_o !== 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA)
      begin n_err++; $display("FAIL st_line got %h want ddddddddccccccccbbbbbbbbaaaaaaaa", dat_o); end
    if (o_cyc.size() !== 4) begin n_err++; $display("FAIL st_beats got %0d want 4", o_cyc.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (o_cyc[i] !== e_cyc[i] || o_addr[i] !== 16 + i)
        begin n_err++; $display("FAIL st_beat%0d got %h@%0d want %h@%0d", i, o_addr[i], o_cyc[i], 16 + i, e_cyc[i]); end
    end
  endtask

  task automatic test_held_stb_abort();
    logic [127:0] line1, want;
    int late;
    ready_all();
    model_txn(16'h0120, 1'b0, 16'hFFFF, 128'h0);
    line1 = model_dat;
    want  = {line1[127:96], ref_mem[194], ref_mem[193], ref_mem[192]};
    keep_stb = 1'b1; adr2 = 16'h0300;
    rdy_pat[9] = 1'b0; rdy_pat[10] = 1'b0; drop_at = 10;
    run_txn(16'h0120, 1'b0, 16'hFFFF, 128'h0);
    late = 0;
    for (int n = 12; n <= NCYC; n++) if (vlog[n]) late++;
    n_vec += 6;
    if (ack_cnt !== 1 || ack_cyc !== 5) begin n_err++; $display("FAIL hs_ack got %0d@%0d want 1@5", ack_cnt, ack_cyc); end
    if (vlog[6] !== 1'b0) begin n_err++; $display("FAIL hs_idle_gap got %0b want 0", vlog[6]); end
    if (late !== 0) begin n_err++; $display("FAIL ab_late_beats got %0d want 0", late); end
    if (hold_viol !== 0) begin n_err++; $display("FAIL ab_hold got %0d want 0", hold_viol); end
    if (dat_o !== want) begin n_err++; $display("FAIL ab_line got %h want %h", dat_o, want); end
    if (o_addr.size() !== 7) begin n_err++; $display("FAIL ab_beats got %0d want 7", o_addr.size()); end
    else begin
      n_vec++;
      if (o_addr[4] !== 192 || o_addr[6] !== 194 || o_cyc[4] !== 7 || o_cyc[6] !== 11)
        begin n_err++; $display("FAIL ab_seq got %h@%0d %h@%0d want c0@7 c2@11", o_addr[4], o_cyc[4], o_addr[6], o_cyc[6]); end
    end
    model_dat = want;
    ready_all();
    model_txn(16'h0300, 1'b0, 16'hFFFF, 128'h0);
    run_txn(16'h0300, 1'b0, 16'hFFFF, 128'h0);
    n_vec += 2;
    if (ack_cyc !== 5 || ack_cnt !== 1) begin n_err++; $display("FAIL ab_next_ack got %0d@%0d want 1@5", ack_cnt, ack_cyc); end
    if (dat_o !== model_dat) begin n_err++; $display("FAIL ab_next_line got %h want %h", dat_o, model_dat); end
  endtask

  task automatic test_reset_mid();
    ready_all();
    @(negedge clk);
    adr_i = 16'h0040; we_i = 1'b0; sel_i = 16'hFFFF; cyc_i = 1'b1; stb_i = 1'b1; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_valid !== 1'b1 || mem_addr !== 14'h011)
      begin n_err++; $display("FAIL rm_pre got %0b/%h want 1/011", mem_valid, mem_addr); end
    #1 rst = 1'b0;
    #1;
    n_vec += 3;
    if (mem_valid !== 1'b0 || ack_o !== 1'b0) begin n_err++; $display("FAIL rm_ctl got %0b/%0b want 0/0", mem_valid, ack_o); end
    if (mem_addr !== 14'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0)
      begin n_err++; $display("FAIL rm_mem got %h/%0b/%h/%h want zeros", mem_addr, mem_we, mem_wdata, mem_wstrb); end
    if (dat_o !== 128'h0) begin n_err++; $display("FAIL rm_dat got %h want 0", dat_o); end
    cyc_i = 1'b0; stb_i = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    model_dat = '0;
    model_txn(16'h0040, 1'b0, 16'hFFFF, 128'h0);
    run_txn(16'h0040, 1'b0, 16'hFFFF, 128'h0);
    n_vec += 2;
    if (ack_cyc !== 5) begin n_err++; $display("FAIL rm_next_ack got %0d want 5", ack_cyc); end
    if (dat_o !== model_dat) begin n_err++; $display("FAIL rm_next_line got %h want %h", dat_o, model_dat); end
  endtask

  task automatic test_random();
    logic [15:0] a, s;
    logic [127:0] d;
    logic w;
    for (int t = 0; t < 40; t++) begin
      ready_all();
      for (int n = 1; n <= 20; n++) rdy_pat[n] = ($urandom_range(0, 3) != 0);
      a = 16'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       s[4*k +: 4] = 4'h0;
          1:       s[4*k +: 4] = 4'hF;
          default: s[4*k +: 4] = 4'($urandom_range(0, 15));
        endcase
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      model_txn(a, w, s, d);
      run_txn(a, w, s, d);
      n_vec += 4;
      if (ack_cyc !== exp_ack || ack_cnt !== 1)
        begin n_err++; $display("FAIL rnd%0d_ack got %0d@%0d want 1@%0d", t, ack_cnt, ack_cyc, exp_ack); end
      if (hold_viol !== 0) begin n_err++; $display("FAIL rnd%0d_hold got %0d want 0", t, hold_viol); end
      if (dat_o !== model_dat) begin n_err++; $display("FAIL rnd%0d_line got %h want %h", t, dat_o, model_dat); end
      if (o_addr.size() !== e_addr.size())
        begin n_err++; $display("FAIL rnd%0d_beats got %0d want %0d", t, o_addr.size(), e_addr.size()); end
      else for (int i = 0; i < e_addr.size(); i++) begin
        n_vec++;
        if (o_addr[i] !== e_addr[i] || o_cyc[i] !== e_cyc[i] ||
            (w && (o_wdata[i] !== e_wdata[i] || o_wstrb[i] !== e_wstrb[i])))
          begin n_err++; $display("FAIL rnd%0d_beat%0d got %h@%0d %h/%h want %h@%0d %h/%h", t, i,
            o_addr[i], o_cyc[i], o_wdata[i], o_wstrb[i], e_addr[i], e_cyc[i], e_wdata[i], e_wstrb[i]); end
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < NWORD; i++) begin
      v = $urandom;
      tb_mem[i] = v;
      ref_mem[i] = v;
    end
    ready_all();
    test_reset();
    test_read_basic();
    test_write_full();
    test_write_sparse();
    test_read_stall();
    test_held_stb_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_line_adapter.md
Name: wb_line_adapter

Overview:
- Wishbone classic responder that accepts 128-bit line transfers from the memory controller's Wishbone initiator.
- Serialises each line into 32-bit beats on a narrow word-memory port (SRAM/flash/SPI-backed store) and assembles read beats back into a line.
- Drop-in alternative to the wide RAM model on the controller's Wishbone bus.

Parameters:
- LINE_W, 128, Wishbone data width in bits.
- ADDR_W, 16, Wishbone byte-address width.
- MEM_W, 32, narrow memory data width. LINE_W must be a power-of-two multiple of MEM_W.
- Derived localparams: BEATS=LINE_W/MEM_W, SEL_W=LINE_W/8, MSTRB_W=MEM_W/8, MADDR_W=ADDR_W-log2(MSTRB_W).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- adr_i  in  ADDR_W  byte address; low log2(SEL_W) bits ignored (line aligned).
- dat_i  in  LINE_W  write line.
- dat_o  out  LINE_W  read line.
- we_i  in  1  write enable.
- sel_i  in  SEL_W  byte selects.
- stb_i  in  1  strobe.
- cyc_i  in  1  bus cycle.
- ack_o  out  1  transfer complete.
- mem_valid  out  1  beat request.
- mem_ready  in  1  beat accepted (transfer when mem_valid && mem_ready).
- mem_addr  out  MADDR_W  word address.
- mem_we  out  1  beat is a write.
- mem_wdata  out  MEM_W  write word.
- mem_wstrb  out  MSTRB_W  byte strobes.
- mem_rdata  in  MEM_W  read word; valid in the transfer cycle.

Behaviour:
- Reset (rst low, async): state IDLE; ack_o=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, dat_o=0, beat counter=0.
- States: IDLE, BEAT, ACK.
- IDLE: on cyc_i&&stb_i, register adr_i, we_i, sel_i, dat_i; beat=0; go to BEAT.
- BEAT, beat index k:
  - mem_addr = {adr[ADDR_W-1:log2(SEL_W)], k}.
  - mem_wdata = dat slice k; mem_wstrb = sel slice k. Beat 0 is the least-significant word.
- Read beats:
  - mem_valid=1, mem_we=0.
  - On transfer, mem_rdata is written into dat_o slice k.
- Write beats:
  - If the sel slice is nonzero: mem_valid=1, mem_we=1.
  - If the sel slice is zero: the beat is skipped; mem_valid=0 for exactly one cycle, then advance.
- Holding: mem_valid and all mem_* outputs stay stable until mem_ready. Never retract an asserted mem_valid.
- Last beat (k=BEATS-1) complete: go to ACK.
- ACK:
  - ack_o=1 for exactly one cycle; dat_o holds the full line.
  - Return to IDLE. Do not sample stb_i in ACK, so a held strobe cannot be captured twice.
  - The next request is captured in the first IDLE cycle after ACK.
- dat_o:
  - Retains its last value after ack.
  - Slices are not cleared at transfer start.
  - On writes, dat_o is unchanged.
- Latency with mem_ready tied high: capture at edge 0, beats on cycles 1..BEATS, ack_o high on cycle BEATS+1 (5 for defaults). Each mem_ready stall adds one cycle.
- Abort: cyc_i low during BEAT.
  - Finish any beat whose mem_valid is already asserted.
  - Then go to IDLE with no ack.
  - No further beats are issued.
- cyc_i low in ACK: ack is still pulsed (harmless).
- Reset mid-transfer: immediate return to the reset state; mem_valid drops asynchronously.
- err/rty are not generated; the initiator ties them low.

Decomposition:
- Shared package wb_pkg:
  - localparams for default widths (LINE_W, ADDR_W, MEM_W).
  - State enum encoding (IDLE=0, BEAT=1, ACK=2).
  - Helper function for log2 of widths.
- Optional sub-module wb_beat_slicer: combinational slice select by beat index (data and strobe). Everything else stays in the top module.

Test Plan:
- Read, mem_ready=1, adr=0x0120, memory words at mem_addr 0x048..0x04B = 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> mem_addr sequence 0x048, 0x049, 0x04A, 0x04B; ack on cycle 5; dat_o=0x44444444_33333333_22222222_11111111.
- Write, adr=0x0040, sel=0xFFFF, dat=0xDDDD..._AAAA... -> four write beats at 0x010..0x013, wstrb=0xF each, wdata per slice; single-cycle ack.
- Write, sel=0x0F00, dat_i=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> exactly one mem transfer, at beat 2 with wstrb=0xF, wdata=0xCCCCCCCC; beats 0, 1, 3 skipped; ack on cycle 5.
- Read with mem_ready low for 3 cycles on beat 1 -> mem_addr/mem_valid held stable; ack on cycle 8; data correct.
- stb_i held high through ack; also a cyc_i drop mid-beat 2 -> no double capture; abort finishes beat 2, issues no beat 3, no ack; next request serviced normally.
- rst asserted during beat 1 of a read -> all outputs zero immediately, state IDLE; a subsequent read completes correctly.
